// File: rtl/branch_imm_encoder.sv
// RV32I B-type instruction encoder: branch request in, packed instruction out.
// Three-state compute FSM feeding a small output FIFO with error tagging.
module branch_imm_encoder #(
    parameter logic [6:0] OPCODE    = 7'b1100011,
    parameter int         OUT_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_target,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_error,
    output logic [7:0]  err_count
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        PACK
    } state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } ent_t;

    state_t state;
    state_t state_nx;

    logic [31:0] pc_q;
    logic [31:0] tgt_q;
    logic [31:0] off_q;
    logic [2:0]  f3_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;

    ent_t          mem [OUT_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic accept;
    logic bad_align;
    logic bad_range;
    logic bad_f3;
    logic bad;
    ent_t pk;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(OUT_DEPTH));
    assign pop    = !empty && out_ready;
    assign accept = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        push     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = reset;
                if (in_valid && reset) state_nx = CALC;
            end
            CALC: state_nx = PACK;
            PACK: begin
                // A same-cycle pop frees a slot even when the FIFO is full.
                if (!full || pop) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bad_align = off_q[0];
    assign bad_range = (off_q[31:12] != {20{off_q[12]}});
    assign bad_f3    = (f3_q[2:1] == 2'b01);
    assign bad       = bad_align || bad_range || bad_f3;

    always_comb begin
        pk.err   = bad;
        pk.instr = NOP;
        if (!bad) begin
            pk.instr = {off_q[12], off_q[10:5], rs2_q, rs1_q,
                        f3_q, off_q[4:1], off_q[11], OPCODE};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            tgt_q <= '0;
            off_q <= '0;
            f3_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            if (accept) begin
                pc_q  <= in_pc;
                tgt_q <= in_target;
                f3_q  <= in_funct3;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
            end
            if (state == CALC) off_q <= tgt_q - pc_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (push && bad && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pk;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = !empty;
    assign out_instr = empty ? '0 : mem[rd_ptr].instr;
    assign out_error = empty ? 1'b0 : mem[rd_ptr].err;

endmodule
